// File: rtl/uart_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_pkg
//  Description : Shared constants and state encoding for the UART transmit
//                scheduler. Frame timing matches the 8N1 byte transmitter
//                (868 clocks per bit, 10 bits per frame).
//  Revision    : 1.0  initial release
// ============================================================================
package uart_tx_pkg;

    localparam int FULL_T           = 867;
    localparam int FRAME_BITS       = 10;
    // One full frame plus the cycle the transmitter needs to re-arm.
    localparam int BYTE_GAP_DEFAULT = FRAME_BITS * (FULL_T + 1) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOCK = 2'd1,
        ST_GAP  = 2'd2
    } sched_state_t;

endpackage : uart_tx_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin picker. Searches the request
//                vector starting one above the pointer (wrapping modulo
//                NUM_REQ) and returns a one-hot grant plus its index.
//                The caller registers the result.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
    output logic [NUM_REQ-1:0]         o_gnt,
    output logic [$clog2(NUM_REQ)-1:0] o_idx
);

    localparam int IW = $clog2(NUM_REQ);

    logic          w_found;
    logic [IW-1:0] w_cand;

    // First asserted request after the pointer wins; the pointer itself is
    // checked last so the previous grantee has lowest priority.
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = IW'((int'(i_ptr) + k) % NUM_REQ);
            if (!w_found && i_req[w_cand]) begin
                w_found       = 1'b1;
                o_gnt[w_cand] = 1'b1;
                o_idx         = w_cand;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_scheduler
//  Description : Shares one pulse-started UART byte transmitter between
//                NUM_REQ byte-stream requesters. A requester keeps the grant
//                for a whole packet; packets are interleaved round-robin.
//                Bytes are paced BYTE_GAP cycles apart by an internal gap
//                counter since the transmitter reports no completion.
//                Optional macro UART_TX_SCHED_TIMEOUT_EN adds a mid-packet
//                stall timeout that drops the grant and pulses timeout_err.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx_scheduler
    import uart_tx_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int BYTE_GAP       = BYTE_GAP_DEFAULT,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_vld,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_rdy,
    output logic                       dout_vld,
    output logic [7:0]                 dout_data,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       timeout_err
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(((BYTE_GAP > TIMEOUT_CYCLES) ? BYTE_GAP : TIMEOUT_CYCLES) + 1);
    // GAP lasts BYTE_GAP-1 cycles; the LOCK handshake cycle completes the period.
    localparam logic [CW-1:0] C_GAP_LOAD = CW'(BYTE_GAP - 2);

    sched_state_t  state_q, state_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic          dout_vld_q, dout_vld_d;
    logic [7:0]    dout_data_q, dout_data_d;
    logic          last_q, last_d;
    logic [CW-1:0] gap_q, gap_d;

    logic [NUM_REQ-1:0] w_arb_gnt;
    logic [IW-1:0]      w_arb_idx;
    logic               w_any_req;
    logic               w_hs;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .i_req (req_vld),
        .i_ptr (ptr_q),
        .o_gnt (w_arb_gnt),
        .o_idx (w_arb_idx)
    );

    assign w_any_req = |w_arb_gnt;
    assign w_hs      = (state_q == ST_LOCK) && req_vld[grant_q];

    // Only the grantee can be accepted, and only while waiting for its next byte.
    always_comb begin
        req_rdy = '0;
        if (state_q == ST_LOCK) begin
            req_rdy[grant_q] = req_vld[grant_q];
        end
    end

`ifdef UART_TX_SCHED_TIMEOUT_EN
    logic [CW-1:0] stall_q, stall_d;
    logic          sent_q, sent_d;
    logic          tout_q, tout_d;
`endif

    // Next-state logic: arbitrate in IDLE, accept in LOCK, pace in GAP.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        dout_vld_d  = 1'b0;
        dout_data_d = dout_data_q;
        last_d      = last_q;
        gap_d       = gap_q;
`ifdef UART_TX_SCHED_TIMEOUT_EN
        stall_d     = stall_q;
        sent_d      = sent_q;
        tout_d      = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (w_any_req) begin
                    grant_d = w_arb_idx;
                    last_d  = 1'b0;
                    state_d = ST_LOCK;
`ifdef UART_TX_SCHED_TIMEOUT_EN
                    sent_d  = 1'b0;
                    stall_d = '0;
`endif
                end
            end
            ST_LOCK: begin
                if (w_hs) begin
                    dout_vld_d  = 1'b1;
                    dout_data_d = req_data[{grant_q, 3'b000} +: 8];
                    last_d      = req_last[grant_q];
                    gap_d       = C_GAP_LOAD;
                    state_d     = ST_GAP;
`ifdef UART_TX_SCHED_TIMEOUT_EN
                    sent_d      = 1'b1;
                    stall_d     = '0;
`endif
                end
`ifdef UART_TX_SCHED_TIMEOUT_EN
                // A stall before the first byte is not a timeout; the grant
                // was only just given.
                else if (sent_q && !last_q) begin
                    if (stall_q == CW'(TIMEOUT_CYCLES - 1)) begin
                        tout_d  = 1'b1;
                        ptr_d   = grant_q;
                        stall_d = '0;
                        state_d = ST_IDLE;
                    end else begin
                        stall_d = stall_q + 1'b1;
                    end
                end
`endif
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    if (last_q) begin
                        ptr_d   = grant_q;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_LOCK;
                    end
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; pointer resets to the top index so requester 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            ptr_q       <= IW'(NUM_REQ - 1);
            dout_vld_q  <= 1'b0;
            dout_data_q <= 8'h00;
            last_q      <= 1'b0;
            gap_q       <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            dout_vld_q  <= dout_vld_d;
            dout_data_q <= dout_data_d;
            last_q      <= last_d;
            gap_q       <= gap_d;
        end
    end

`ifdef UART_TX_SCHED_TIMEOUT_EN
    // Stall watchdog state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
            sent_q  <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            stall_q <= stall_d;
            sent_q  <= sent_d;
            tout_q  <= tout_d;
        end
    end

    assign timeout_err = tout_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign dout_vld  = dout_vld_q;
    assign dout_data = dout_data_q;
    assign grant_id  = grant_q;
    assign busy      = (state_q != ST_IDLE);

endmodule : uart_tx_scheduler
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_scheduler
//  Description : Scoreboard bench for uart_tx_scheduler. Requester drivers
//                play queued packets; a packet-level round-robin model
//                predicts the (grantee, byte) stream; a monitor pops and
//                compares on every dout_vld pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_tx_scheduler;

    localparam int NR  = 4;
    localparam int GAP = 20;
    localparam int TMO = 100;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
        logic       last;
        logic       first;
        int         stall;
    } ent_t;

    logic            clk      = 1'b0;
    logic            rst      = 1'b1;
    logic [NR-1:0]   req_vld  = '0;
    logic [8*NR-1:0] req_data = '0;
    logic [NR-1:0]   req_last = '0;
    logic [NR-1:0]   req_rdy;
    logic            dout_vld;
    logic [7:0]      dout_data;
    logic [1:0]      grant_id;
    logic            busy;
    logic            timeout_err;

    ent_t       tx_q[$];
    logic [9:0] exp_q[$];
    int         pulse_t[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         mptr     = NR - 1;
    int         last_pulse_t = -1;
    int         busy_fall_t  = -1;
    int         tout_t   = -1;
    int         tout_cnt = 0;
    logic       tout_busy = 1'b0;
    int         rise_t[NR];
    logic [NR-1:0] hs = '0;

    uart_tx_scheduler #(
        .NUM_REQ        (NR),
        .BYTE_GAP       (GAP),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_vld     (req_vld),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_rdy     (req_rdy),
        .dout_vld    (dout_vld),
        .dout_data   (dout_data),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic chk_rng(input string nm, input int got, input int lo, input int hi);
        n_checks++;
        if (got < lo || got > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", nm, got, lo, hi, cyc);
        end
    endtask

    function automatic int head_idx(input int id);
        for (int k = 0; k < tx_q.size(); k++)
            if (int'(tx_q[k].id) == id) return k;
        return -1;
    endfunction

    // Queue a packet of n bytes for requester id. stall<0 picks random
    // inter-byte stalls; the first byte of a packet is never delayed.
    task automatic add_pkt(input int id, input int n, input logic [7:0] d0, input bit rnd, input int stall);
        ent_t e;
        for (int k = 0; k < n; k++) begin
            e.id    = 2'(id);
            e.data  = rnd ? 8'($urandom) : d0 + 8'(k);
            e.last  = (k == n - 1);
            e.first = (k == 0);
            if (k == 0)          e.stall = 0;
            else if (stall >= 0) e.stall = stall;
            else                 e.stall = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 12)) : 0;
            tx_q.push_back(e);
        end
    endtask

    // Packet-level reference: serve whole packets, choosing the next
    // requester with pending packets after the previous grantee.
    task automatic predict();
        ent_t work[$];
        int   c;
        int   idx;
        bit   found;
        bit   done;
        work = tx_q;
        while (work.size() > 0) begin
            found = 1'b0;
            c     = 0;
            for (int k = 1; k <= NR; k++) begin
                if (!found) begin
                    c = (mptr + k) % NR;
                    for (int j = 0; j < work.size(); j++)
                        if (int'(work[j].id) == c) found = 1'b1;
                end
            end
            done = 1'b0;
            while (!done) begin
                idx = -1;
                for (int j = work.size() - 1; j >= 0; j--)
                    if (int'(work[j].id) == c) idx = j;
                exp_q.push_back({2'(c), work[idx].data});
                done = work[idx].last;
                work.delete(idx);
            end
            mptr = c;
        end
    endtask

    task automatic clear_tb();
        tx_q.delete();
        exp_q.delete();
        hs           = '0;
        req_vld      = '0;
        last_pulse_t = -1;
        mptr         = NR - 1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        clear_tb();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while ((tx_q.size() != 0 || exp_q.size() != 0 || busy) && k < 6000) begin
            @(negedge clk);
            k++;
        end
        chk("drain_outstanding", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_pulses(input int n, input int budget);
        int k;
        k = 0;
        while (pulse_t.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("wait_pulses", pulse_t.size(), n);
    endtask

    // Requester drivers: present the head byte of each requester, retire it
    // one negedge after a handshake edge.
    initial begin : driver
        int   h;
        ent_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                req_vld = '0;
            end else begin
                for (int i = 0; i < NR; i++) begin
                    if (hs[i]) begin
                        h = head_idx(i);
                        if (h >= 0) tx_q.delete(h);
                        hs[i] = 1'b0;
                    end
                    h = head_idx(i);
                    if (h < 0) begin
                        req_vld[i] = 1'b0;
                    end else begin
                        e = tx_q[h];
                        if (e.stall > 0) begin
                            e.stall    = e.stall - 1;
                            tx_q[h]    = e;
                            req_vld[i] = 1'b0;
                        end else begin
                            if (!req_vld[i] && !e.first) rise_t[i] = cyc;
                            req_vld[i]          = 1'b1;
                            req_data[8*i +: 8]  = e.data;
                            req_last[i]         = e.last;
                        end
                    end
                end
                #1;
                hs = req_vld & req_rdy;
            end
        end
    end

    // Monitor: scoreboard pops on each pulse, plus per-cycle ready legality.
    initial begin : monitor
        logic [9:0] e;
        logic       prev_busy;
        logic       ok;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (dout_vld) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_pulse: got id %0d data %h, expected no pulse (cycle %0d)",
                                 grant_id, dout_data, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("pulse_id_data", {22'd0, grant_id, dout_data}, {22'd0, e});
                    end
                    if (last_pulse_t >= 0) chk_rng("pulse_spacing", cyc - last_pulse_t, GAP, 1000000);
                    last_pulse_t = cyc;
                    pulse_t.push_back(cyc);
                end
                ok = (req_rdy == '0) ||
                     ((req_rdy == (NR'(1) << grant_id)) && req_vld[grant_id]);
                n_checks++;
                if (!ok) begin
                    n_fail++;
                    $display("FAIL rdy_grantee_only: got rdy %b (vld %b, grant %0d), expected 0 or grantee bit",
                             req_rdy, req_vld, grant_id);
                end
                if (prev_busy && !busy) busy_fall_t = cyc;
                if (timeout_err) begin
                    tout_cnt++;
                    tout_t    = cyc;
                    tout_busy = busy;
                end
            end
            prev_busy = rst ? 1'b0 : busy;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        for (int i = 0; i < NR; i++) rise_t[i] = -1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_dout_vld", dout_vld, 0);
        chk("rst_dout_data", dout_data, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_req_rdy", req_rdy, 0);
        rst = 1'b0;

        // Single 3-byte packet from requester 0
        pulse_t.delete();
        add_pkt(0, 3, 8'h41, 1'b0, 0);
        predict();
        wait_drain();
        chk("t1_pulse_count", pulse_t.size(), 3);
        if (pulse_t.size() == 3) begin
            chk("t1_spacing_01", pulse_t[1] - pulse_t[0], GAP);
            chk("t1_spacing_12", pulse_t[2] - pulse_t[1], GAP);
            chk_rng("t1_busy_fall", busy_fall_t - pulse_t[2], GAP - 1, GAP);
        end

        // Simultaneous 2-byte packets from requesters 0 and 2 after reset
        do_reset();
        pulse_t.delete();
        add_pkt(0, 2, 8'h10, 1'b0, 0);
        add_pkt(2, 2, 8'h20, 1'b0, 0);
        predict();
        wait_drain();
        chk("t2_pulse_count", pulse_t.size(), 4);

        // Round robin of single-byte packets
        pulse_t.delete();
        add_pkt(0, 1, 8'hA0, 1'b0, 0);
        add_pkt(0, 1, 8'hA0, 1'b0, 0);
        add_pkt(1, 1, 8'hB1, 1'b0, 0);
        add_pkt(1, 1, 8'hB1, 1'b0, 0);
        predict();
        wait_drain();
        chk("t3_pulse_count", pulse_t.size(), 4);

        // Mid-packet stall on requester 1
        pulse_t.delete();
        add_pkt(1, 2, 8'h61, 1'b0, 50);
        predict();
        wait_pulses(1, 200);
        repeat (30) @(negedge clk);
        chk("t4_stall_busy", busy, 1);
        chk("t4_stall_grant", grant_id, 1);
        chk("t4_stall_no_pulse", pulse_t.size(), 1);
        wait_drain();
        chk("t4_pulse_count", pulse_t.size(), 2);
        if (pulse_t.size() == 2) chk("t4_pulse_after_hs", pulse_t[1] - rise_t[1], 1);

        // Asynchronous reset between clock edges during GAP
        pulse_t.delete();
        add_pkt(1, 3, 8'h71, 1'b0, 0);
        predict();
        wait_pulses(1, 200);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_async_dout_vld", dout_vld, 0);
        chk("t5_async_busy", busy, 0);
        chk("t5_async_grant", grant_id, 0);
        clear_tb();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pulse_t.delete();
        add_pkt(1, 1, 8'h81, 1'b0, 0);
        add_pkt(0, 1, 8'h80, 1'b0, 0);
        predict();
        wait_drain();
        chk("t5_pulse_count", pulse_t.size(), 2);

        // Randomized packet mixes
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NR; i++) begin
                if ($urandom_range(0, 2) != 0) begin
                    int np;
                    np = int'($urandom_range(1, 2));
                    for (int p = 0; p < np; p++)
                        add_pkt(i, int'($urandom_range(1, 4)), 8'h00, 1'b1, -1);
                end
            end
            predict();
            wait_drain();
        end

`ifdef UART_TX_SCHED_TIMEOUT_EN
        // Requester 3 goes silent mid-packet; requester 0 waits behind it
        do_reset();
        pulse_t.delete();
        tout_cnt = 0;
        add_pkt(3, 2, 8'h33, 1'b0, 300);
        exp_q.push_back({2'd3, 8'h33});
        wait_pulses(1, 200);
        add_pkt(0, 1, 8'h50, 1'b0, 0);
        exp_q.push_back({2'd0, 8'h50});
        begin
            int k;
            k = 0;
            while (exp_q.size() != 0 && k < 400) begin
                @(negedge clk);
                k++;
            end
        end
        chk("t7_outstanding", exp_q.size(), 0);
        chk("t7_timeout_count", tout_cnt, 1);
        if (pulse_t.size() >= 1)
            chk_rng("t7_timeout_delay", tout_t - (pulse_t[0] + GAP - 1), TMO - 1, TMO + 1);
        chk("t7_timeout_busy", tout_busy, 0);
        do_reset();
`else
        chk("no_timeout_pulse", tout_cnt, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_uart_tx_scheduler
`default_nettype wire
